instruction_sequencer: RTL and testbench

Program sequencer that sits in front of `control_circuit` and drives its `INSTRUCTION` bus. It holds a small writable program memory and issues one 11-bit instruction at a time. It holds each instruction stable until `control_circuit` pulses `Done`, then advances to the next entry. It stops on a HALT entry, at the end of memory, on a requested abort, or on a watchdog timeout.

---
 rtl/instruction_sequencer_pkg.sv | 17 +
 rtl/instruction_sequencer_program_memory.sv | 24 ++
 rtl/instruction_sequencer.sv | 145 ++++++++++++++
 tb/tb_instruction_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and the control circuit it feeds:
// instruction field widths, opcode constants and the NOP word.
package instruction_sequencer_pkg;

  localparam int INSTR_W = 11;
  localparam int OPC_W   = 3;
  localparam int OPR_W   = 8;

  localparam logic [OPC_W-1:0] OP_LOAD = 3'b000;
  localparam logic [OPC_W-1:0] OP_MOV  = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OPC_W-1:0] OP_SUB  = 3'b011;
  localparam logic [OPC_W-1:0] OP_HALT = 3'b111;

  localparam logic [INSTR_W-1:0] NOP_WORD = {OP_HALT, {OPR_W{1'b0}}};

endpackage

// File: rtl/instruction_sequencer_program_memory.sv
// Program store: DEPTH x INSTR_W register array, one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module program_memory #(
  parameter int INSTR_W = 11,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_sequencer.sv
// Issues program words one at a time to control_circuit, advancing on each Done pulse;
// stops on HALT, end of memory, abort or watchdog timeout.
module instruction_sequencer #(
  parameter int INSTR_W  = instruction_sequencer_pkg::INSTR_W,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int WDOG_MAX = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic               abort,
  input  logic               Done,
  output logic [INSTR_W-1:0] INSTRUCTION,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               error,
  output logic [7:0]         instr_count
);

  import instruction_sequencer_pkg::*;

  // Handshake: a word on INSTRUCTION is held until Done is sampled high at a rising
  // edge; the next word (or NOP) is presented at that same edge.

  localparam int WDOG_W = $clog2(WDOG_MAX + 1);
  localparam logic [INSTR_W-1:0] NOP = {OP_HALT, {(INSTR_W-OPC_W){1'b0}}};
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED, S_FAULT} state_t;

  state_t             state, state_n;
  logic [INSTR_W-1:0] instr_n;
  logic [ADDR_W-1:0]  pc_n, pc_inc, rd_addr;
  logic [7:0]         count_n;
  logic [WDOG_W-1:0]  wdog, wdog_n;
  logic               abort_pending, abort_pending_n;
  logic               mem_we;
  logic [INSTR_W-1:0] rd_word;
  logic               rd_is_halt;

  // One read port serves both lookups: mem[0] when launching, mem[pc+1] while running.
  assign pc_inc     = pc + ADDR_W'(1);
  assign rd_addr    = (state == S_RUN) ? pc_inc : '0;
  assign rd_is_halt = (rd_word[INSTR_W-1 -: OPC_W] == OP_HALT);

  program_memory #(
    .INSTR_W(INSTR_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_program_memory (
    .clk  (clk),
    .we   (mem_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(rd_addr),
    .rdata(rd_word)
  );

  always_comb begin
    state_n         = state;
    instr_n         = INSTRUCTION;
    pc_n            = pc;
    count_n         = instr_count;
    wdog_n          = wdog;
    abort_pending_n = abort_pending;
    mem_we          = 1'b0;
    case (state)
      S_RUN: begin
        if (Done) begin
          count_n = (instr_count == 8'hFF) ? instr_count : instr_count + 8'd1;
          wdog_n  = '0;
          if (abort_pending || abort) begin
            state_n         = S_IDLE;
            instr_n         = NOP;
            abort_pending_n = 1'b0;
          end else if (pc == LAST_ADDR) begin
            state_n = S_HALTED;
            instr_n = NOP;
          end else if (rd_is_halt) begin
            pc_n    = pc_inc;
            state_n = S_HALTED;
            instr_n = NOP;
          end else begin
            pc_n    = pc_inc;
            instr_n = rd_word;
          end
        end else if (wdog == WDOG_W'(WDOG_MAX - 1)) begin
          state_n         = S_FAULT;
          instr_n         = NOP;
          wdog_n          = '0;
          abort_pending_n = 1'b0;
        end else begin
          wdog_n = wdog + WDOG_W'(1);
          if (abort) abort_pending_n = 1'b1;
        end
      end
      default: begin
        // start wins over a simultaneous program write
        if (start) begin
          pc_n            = '0;
          count_n         = '0;
          wdog_n          = '0;
          abort_pending_n = 1'b0;
          if (rd_is_halt) begin
            state_n = S_HALTED;
            instr_n = NOP;
          end else begin
            state_n = S_RUN;
            instr_n = rd_word;
          end
        end else begin
          mem_we = prog_we;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      INSTRUCTION   <= NOP;
      pc            <= '0;
      instr_count   <= '0;
      wdog          <= '0;
      abort_pending <= 1'b0;
    end else begin
      state         <= state_n;
      INSTRUCTION   <= instr_n;
      pc            <= pc_n;
      instr_count   <= count_n;
      wdog          <= wdog_n;
      abort_pending <= abort_pending_n;
    end
  end

  assign busy   = (state == S_RUN);
  assign halted = (state == S_HALTED);
  assign error  = (state == S_FAULT);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: a control_circuit model answers each issued word with
// Done after its opcode latency, and a queue holds the words expected to be issued.
module tb_instruction_sequencer;

  import instruction_sequencer_pkg::*;

  localparam int IW    = 11;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam logic [IW-1:0] NOPW = {3'b111, 8'h00};

  logic          clk = 1'b0;
  logic          reset, prog_we, start, abort, Done;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic [IW-1:0] INSTRUCTION;
  logic [AW-1:0] pc;
  logic          busy, halted, error;
  logic [7:0]    instr_count;

  logic [IW-1:0] mem_model [DEPTH];
  logic [IW-1:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instruction_sequencer #(
    .INSTR_W(IW), .DEPTH(DEPTH), .ADDR_W(AW), .WDOG_MAX(8)
  ) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .abort(abort), .Done(Done),
    .INSTRUCTION(INSTRUCTION), .pc(pc), .busy(busy), .halted(halted),
    .error(error), .instr_count(instr_count)
  );

  function automatic logic [IW-1:0] mk(input logic [2:0] op, input logic [7:0] arg);
    return {op, arg};
  endfunction

  function automatic int latency(input logic [IW-1:0] w);
    if (w[10:8] == OP_ADD || w[10:8] == OP_SUB) return 4;
    return 2;
  endfunction

  // ---------------- driver tasks (all entered and left at posedge + 1) ----------------
  task automatic write_mem(input int a, input logic [IW-1:0] d);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
    mem_model[a] = d;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_expected(input int limit);
    for (int i = 0; i < DEPTH && i < limit; i++) begin
      if (mem_model[i][10:8] == OP_HALT) break;
      exp_q.push_back(mem_model[i]);
    end
  endtask

  // control_circuit model: checks each issue against the scoreboard, checks the word is
  // held stable, and raises Done so it is sampled 'latency' edges after the issue.
  task automatic run_model(input int abort_pc, input int stop_pc, input int budget);
    int held, lat;
    logic [IW-1:0] cur, want;
    held = 0; lat = 0; cur = NOPW;
    for (int c = 0; c < budget; c++) begin
      if (!busy) return;
      if (held == 0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL issue_unexpected: got %h at pc=%0d, no word expected", INSTRUCTION, pc);
        end else begin
          want = exp_q.pop_front();
          if (INSTRUCTION !== want) begin
            bad++;
            $display("FAIL issue_word pc=%0d: got %h want %h", pc, INSTRUCTION, want);
          end
        end
        cur = INSTRUCTION;
        lat = latency(cur);
        if (int'(pc) == stop_pc) return;
      end else begin
        total++;
        if (INSTRUCTION !== cur) begin
          bad++;
          $display("FAIL hold_word cycle=%0d: got %h want %h", held, INSTRUCTION, cur);
        end
      end
      held++;
      Done  = (held == lat);
      abort = (held == 1 && int'(pc) == abort_pc);
      @(posedge clk); #1;
      abort = 1'b0;
      if (Done) begin
        Done = 1'b0;
        held = 0;
      end
    end
    total++; bad++;
    $display("FAIL run_timeout: busy=%b after %0d cycles, want 0", busy, budget);
  endtask

  task automatic check_end(input string name, input logic h, input int epc, input int ecnt);
    total++;
    if ({busy, halted, error, pc, instr_count, INSTRUCTION} !== {1'b0, h, 1'b0, AW'(epc), 8'(ecnt), NOPW}) begin
      bad++;
      $display("FAIL %s: got busy=%b halted=%b error=%b pc=%0d count=%0d instr=%h want busy=0 halted=%b error=0 pc=%0d count=%0d instr=%h",
               name, busy, halted, error, pc, instr_count, INSTRUCTION, h, epc, ecnt, NOPW);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_issues: got %0d words never issued want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic load_mixed();
    write_mem(0, mk(OP_LOAD, 8'h15));
    write_mem(1, mk(OP_LOAD, 8'h2A));
    write_mem(2, mk(OP_ADD,  8'h12));
    write_mem(3, mk(OP_SUB,  8'h21));
    write_mem(4, mk(OP_MOV,  8'h13));
    write_mem(5, NOPW);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; prog_we = 1'b0; start = 1'b0; abort = 1'b0; Done = 1'b0;
    prog_addr = '0; prog_data = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({INSTRUCTION, pc, instr_count, busy, halted, error} !== {NOPW, 4'd0, 8'd0, 3'b000}) begin
      bad++;
      $display("FAIL reset_values: got instr=%h pc=%0d count=%0d flags=%b%b%b want instr=%h pc=0 count=0 flags=000",
               INSTRUCTION, pc, instr_count, busy, halted, error, NOPW);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_halt();
    write_mem(0, mk(OP_LOAD, 8'h15));
    write_mem(1, NOPW);
    push_expected(DEPTH);
    pulse_start();
    total++;
    if ({busy, INSTRUCTION, pc} !== {1'b1, mem_model[0], 4'd0}) begin
      bad++;
      $display("FAIL start_latency: got busy=%b instr=%h pc=%0d want busy=1 instr=%h pc=0",
               busy, INSTRUCTION, pc, mem_model[0]);
    end
    run_model(-1, -1, 100);
    check_end("load_halt", 1'b1, 1, 1);
  endtask

  task automatic test_mixed();
    load_mixed();
    push_expected(DEPTH);
    pulse_start();
    run_model(-1, -1, 200);
    check_end("mixed", 1'b1, 5, 5);
  endtask

  task automatic test_end_of_memory();
    for (int i = 0; i < DEPTH; i++) write_mem(i, mk(OP_MOV, 8'(8'h40 + $urandom_range(0, 63))));
    push_expected(DEPTH);
    pulse_start();
    run_model(-1, -1, 300);
    check_end("end_of_memory", 1'b1, 15, 16);
  endtask

  task automatic test_abort();
    load_mixed();
    push_expected(3);
    pulse_start();
    run_model(2, -1, 200);
    check_end("abort", 1'b0, 2, 3);
    // abort while idle must not leave anything pending for the next run
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    push_expected(DEPTH);
    pulse_start();
    run_model(-1, -1, 200);
    check_end("abort_idle_ignored", 1'b1, 5, 5);
  endtask

  task automatic test_watchdog();
    pulse_start();
    repeat (7) @(posedge clk);
    #1;
    total++;
    if ({busy, error} !== 2'b10) begin
      bad++;
      $display("FAIL wdog_early: got busy=%b error=%b after 7 cycles want busy=1 error=0", busy, error);
    end
    @(posedge clk); #1;
    total++;
    if ({busy, error, pc, INSTRUCTION} !== {1'b0, 1'b1, 4'd0, NOPW}) begin
      bad++;
      $display("FAIL wdog_fault: got busy=%b error=%b pc=%0d instr=%h want busy=0 error=1 pc=0 instr=%h",
               busy, error, pc, INSTRUCTION, NOPW);
    end
    Done = 1'b1;
    @(posedge clk); #1;
    Done = 1'b0;
    total++;
    if ({error, instr_count} !== {1'b1, 8'd0}) begin
      bad++;
      $display("FAIL done_in_fault: got error=%b count=%0d want error=1 count=0", error, instr_count);
    end
    push_expected(DEPTH);
    pulse_start();
    total++;
    if ({error, busy, pc} !== {1'b0, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL wdog_restart: got error=%b busy=%b pc=%0d want error=0 busy=1 pc=0", error, busy, pc);
    end
    run_model(-1, -1, 200);
    check_end("wdog_recover", 1'b1, 5, 5);
  endtask

  task automatic test_writes();
    write_mem(1, NOPW);
    push_expected(DEPTH);
    pulse_start();
    // write during RUN: must be ignored, so the program still halts after one word
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = mk(OP_MOV, 8'h77);
    @(posedge clk); #1;
    prog_we = 1'b0;
    run_model(-1, -1, 100);
    check_end("write_in_run", 1'b1, 1, 1);
    // write together with start: dropped, so mem[0] stays a load
    push_expected(DEPTH);
    start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = NOPW;
    @(posedge clk); #1;
    start = 1'b0; prog_we = 1'b0;
    run_model(-1, -1, 100);
    check_end("write_with_start", 1'b1, 1, 1);
    push_expected(DEPTH);
    pulse_start();
    run_model(-1, -1, 100);
    check_end("write_with_start_rerun", 1'b1, 1, 1);
    // a HALT at address 0 halts straight from start
    write_mem(0, NOPW);
    pulse_start();
    check_end("halt_at_zero", 1'b1, 0, 0);
  endtask

  task automatic test_reset_mid_add();
    write_mem(0, mk(OP_LOAD, 8'h05));
    write_mem(1, mk(OP_ADD,  8'h06));
    write_mem(2, NOPW);
    push_expected(DEPTH);
    pulse_start();
    run_model(-1, 1, 100);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({INSTRUCTION, pc, instr_count, busy, halted, error} !== {NOPW, 4'd0, 8'd0, 3'b000}) begin
      bad++;
      $display("FAIL async_reset: got instr=%h pc=%0d count=%0d flags=%b%b%b want instr=%h pc=0 count=0 flags=000",
               INSTRUCTION, pc, instr_count, busy, halted, error, NOPW);
    end
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    // memory survives reset
    push_expected(DEPTH);
    pulse_start();
    run_model(-1, -1, 100);
    check_end("after_reset", 1'b1, 2, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t want finished", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_load_halt();
    test_mixed();
    test_end_of_memory();
    test_abort();
    test_watchdog();
    test_writes();
    test_reset_mid_add();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
